// File: rtl/y86_pkg.sv
// Shared Y86-64 write-back definitions: instruction codes, special register
// specifiers and the write-back sequencer state encoding.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_port_sequencer_if.sv
// Retire bus between the SEQ core and the write-back sequencer.
// The core is the master (offers one retiring instruction); the sequencer is
// the slave and answers with wb_ready.
interface wb_port_sequencer_if #(
  parameter int DW = 64
);

  logic          wb_valid;
  logic          wb_ready;
  logic [3:0]    icode;
  logic [3:0]    rA;
  logic [3:0]    rB;
  logic          cnd;
  logic [DW-1:0] valE;
  logic [DW-1:0] valM;

  modport master (
    output wb_valid, icode, rA, rB, cnd, valE, valM,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, icode, rA, rB, cnd, valE, valM,
    output wb_ready
  );

endinterface

// File: rtl/wb_dest_decode.sv
// Combinational destination decode for a retiring Y86-64 instruction.
// Produces the E and M destination registers (RNONE when unused) and flags
// instruction codes outside the defined set.
module wb_dest_decode
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  input  logic [3:0] i_ra,
  input  logic [3:0] i_rb,
  input  logic       i_cnd,
  output logic [3:0] o_dst_e,
  output logic [3:0] o_dst_m,
  output logic       o_bad
);

  // Map the instruction class to its register-file destinations.
  always_comb begin
    o_dst_e = RNONE;
    o_dst_m = RNONE;
    o_bad   = 1'b0;
    case (i_icode)
      ICODE_CMOVXX:                       o_dst_e = i_cnd ? i_rb : RNONE;
      ICODE_IRMOVQ, ICODE_OPQ:            o_dst_e = i_rb;
      ICODE_MRMOVQ:                       o_dst_m = i_ra;
      ICODE_CALL, ICODE_RET, ICODE_PUSHQ: o_dst_e = RSP;
      ICODE_POPQ: begin
        o_dst_e = RSP;
        o_dst_m = i_ra;
      end
      ICODE_HALT, ICODE_NOP, ICODE_RMMOVQ, ICODE_JXX: ;
      default:                            o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_port_sequencer.sv
// Write-back sequencer for the SEQ Y86-64 core.
// Serialises up to two register-file writes per retiring instruction onto a
// single registered write port (E write first, then M write) and publishes a
// pending-write mask for RAW hazard stalls.
// Optional build macro WB_FWD_EN adds a combinational forwarding lookup
// (fwd_addr / fwd_hit / fwd_data) over the writes still in flight.
module wb_port_sequencer
  import y86_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_port_sequencer_if.slave wb,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic [NREGS-1:0] pend_mask,
  output logic             halted,
  output logic             bad_icode
`ifdef WB_FWD_EN
  ,
  input  logic [3:0]       fwd_addr,
  output logic             fwd_hit,
  output logic [DW-1:0]    fwd_data
`endif
);

  wb_state_t        r_state;
  wb_state_t        w_state_next;
  wb_state_t        w_load_state;

  logic [3:0]       r_dst_e;
  logic [3:0]       r_dst_m;
  logic [DW-1:0]    r_val_e;
  logic [DW-1:0]    r_val_m;
  logic [3:0]       w_dst_e_next;
  logic [3:0]       w_dst_m_next;
  logic [DW-1:0]    w_val_e_next;
  logic [DW-1:0]    w_val_m_next;

  logic             r_rf_we;
  logic [3:0]       r_rf_waddr;
  logic [DW-1:0]    r_rf_wdata;
  logic             w_rf_we_next;
  logic [3:0]       w_rf_waddr_next;
  logic [DW-1:0]    w_rf_wdata_next;

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_set;
  logic [NREGS-1:0] w_pend_clr;

  logic             r_halted;
  logic             r_bad_icode;

  logic [3:0]       w_dec_e;
  logic [3:0]       w_dec_m;
  logic             w_dec_bad;
  logic             w_ready;
  logic             w_accept;

  wb_dest_decode u_dest_decode (
    .i_icode (wb.icode),
    .i_ra    (wb.rA),
    .i_rb    (wb.rB),
    .i_cnd   (wb.cnd),
    .o_dst_e (w_dec_e),
    .o_dst_m (w_dec_m),
    .o_bad   (w_dec_bad)
  );

  // Ready whenever the current state is about to issue its last write (or is
  // idle), so a new instruction can follow without a bubble. Halt blocks all.
  assign w_ready  = ~r_halted &
                    ((r_state == IDLE) ||
                     ((r_state == WR_E) && (r_dst_m == RNONE)) ||
                     (r_state == WR_M));
  assign w_accept = wb.wb_valid & w_ready;

  // First write state for a freshly accepted instruction.
  assign w_load_state = (w_dec_e != RNONE) ? WR_E :
                        (w_dec_m != RNONE) ? WR_M : IDLE;

  // Destinations and values are latched only on accept; busy-time input
  // changes are ignored.
  assign w_dst_e_next = w_accept ? w_dec_e   : r_dst_e;
  assign w_dst_m_next = w_accept ? w_dec_m   : r_dst_m;
  assign w_val_e_next = w_accept ? wb.valE   : r_val_e;
  assign w_val_m_next = w_accept ? wb.valM   : r_val_m;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: walk E then M, reloading directly from a last-write state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_accept ? w_load_state : IDLE;
      WR_E: begin
        if (r_dst_m != RNONE) w_state_next = WR_M;
        else                  w_state_next = w_accept ? w_load_state : IDLE;
      end
      WR_M:    w_state_next = w_accept ? w_load_state : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs: the port registers are loaded with the write belonging to the
  // state being entered, so the port always shows the current state's write.
  always_comb begin
    w_rf_we_next    = 1'b0;
    w_rf_waddr_next = RNONE;
    w_rf_wdata_next = '0;
    case (w_state_next)
      WR_E: begin
        w_rf_we_next    = 1'b1;
        w_rf_waddr_next = w_dst_e_next;
        w_rf_wdata_next = w_val_e_next;
      end
      WR_M: begin
        w_rf_we_next    = 1'b1;
        w_rf_waddr_next = w_dst_m_next;
        w_rf_wdata_next = w_val_m_next;
      end
      default: ;
    endcase
  end

  // Per-register pending bookkeeping. A bit clears in the cycle its write is
  // on the port; for popq %rsp the E write leaves the bit set because the M
  // write to the same register is still to come. Set has priority over clear.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
      localparam logic [3:0] REG_IDX = 4'(gi);
      assign w_pend_set[gi] = w_accept && (REG_IDX != RNONE) &&
                              ((w_dec_e == REG_IDX) || (w_dec_m == REG_IDX));
      assign w_pend_clr[gi] = ((r_state == WR_E) && (r_dst_e == REG_IDX) &&
                               (r_dst_m != REG_IDX)) ||
                              ((r_state == WR_M) && (r_dst_m == REG_IDX));
    end
  endgenerate

  // Capture registers, write-port registers, pending mask and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dst_e     <= RNONE;
      r_dst_m     <= RNONE;
      r_val_e     <= '0;
      r_val_m     <= '0;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= RNONE;
      r_rf_wdata  <= '0;
      r_pend      <= '0;
      r_halted    <= 1'b0;
      r_bad_icode <= 1'b0;
    end else begin
      r_dst_e     <= w_dst_e_next;
      r_dst_m     <= w_dst_m_next;
      r_val_e     <= w_val_e_next;
      r_val_m     <= w_val_m_next;
      r_rf_we     <= w_rf_we_next;
      r_rf_waddr  <= w_rf_waddr_next;
      r_rf_wdata  <= w_rf_wdata_next;
      r_pend      <= (r_pend & ~w_pend_clr) | w_pend_set;
      if (w_accept && (wb.icode == ICODE_HALT)) r_halted    <= 1'b1;
      if (w_accept && w_dec_bad)                r_bad_icode <= 1'b1;
    end
  end

  assign wb.wb_ready = w_ready;
  assign rf_we       = r_rf_we;
  assign rf_waddr    = r_rf_waddr;
  assign rf_wdata    = r_rf_wdata;
  assign pend_mask   = r_pend;
  assign halted      = r_halted;
  assign bad_icode   = r_bad_icode;

`ifdef WB_FWD_EN
  // Forwarding lookup over writes not yet issued; the M write lands last, so
  // it takes precedence when both destinations match.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != RNONE) begin
      if (((r_state == WR_E) || (r_state == WR_M)) && (r_dst_m == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_val_m;
      end else if ((r_state == WR_E) && (r_dst_e == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_val_e;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Directed bench for wb_port_sequencer. Inputs change 1ns after posedge,
// outputs are sampled on negedge. Build with WB_FWD_EN to exercise forwarding.
module tb_wb_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [15:0] pend_mask;
  logic        halted;
  logic        bad_icode;
`ifdef WB_FWD_EN
  logic [3:0]  fwd_addr = 4'hF;
  logic        fwd_hit;
  logic [63:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_sequencer_if #(.DW(64)) bus ();

  wb_port_sequencer #(.NREGS(16), .DW(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask),
    .halted    (halted),
    .bad_icode (bad_icode)
`ifdef WB_FWD_EN
    ,
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One cycle: apply inputs after posedge, then wait to the sampling edge.
  task automatic cyc(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                     input logic [3:0] rb, input logic c,
                     input logic [63:0] ve, input logic [63:0] vm);
    @(posedge clk);
    #1;
    bus.wb_valid = v;
    bus.icode    = ic;
    bus.rA       = ra;
    bus.rB       = rb;
    bus.cnd      = c;
    bus.valE     = ve;
    bus.valM     = vm;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'hDEAD, 64'hBEEF);
  endtask

  task automatic port(input string tag, input logic we, input logic [3:0] a,
                      input logic [63:0] d, input logic [15:0] pm);
    check({tag, "_we"},   {63'd0, rf_we}, {63'd0, we});
    if (we) begin
      check({tag, "_addr"}, {60'd0, rf_waddr}, {60'd0, a});
      check({tag, "_data"}, rf_wdata, d);
    end
    check({tag, "_pend"}, {48'd0, pend_mask}, {48'd0, pm});
  endtask

  initial begin
    bus.wb_valid = 1'b0;
    bus.icode = 4'h1; bus.rA = 4'hF; bus.rB = 4'hF; bus.cnd = 1'b0;
    bus.valE = '0; bus.valM = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we",    {63'd0, rf_we}, 64'd0);
    check("rst_waddr", {60'd0, rf_waddr}, 64'hF);
    check("rst_wdata", rf_wdata, 64'd0);
    check("rst_pend",  {48'd0, pend_mask}, 64'd0);
    check("rst_halt",  {63'd0, halted}, 64'd0);
    check("rst_bad",   {63'd0, bad_icode}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // irmovq rB=3
    cyc(1'b1, 4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0);
    check("irm_ready", {63'd0, bus.wb_ready}, 64'd1);
    idle();
    port("irm_w", 1'b1, 4'h3, 64'h1234, 16'h0008);
    idle();
    port("irm_done", 1'b0, 4'h0, 64'h0, 16'h0000);

    // popq rA=2: E write to rsp, then M write to r2; inputs scrambled while busy
    cyc(1'b1, 4'hB, 4'h2, 4'hF, 1'b0, 64'h108, 64'hAB);
    idle();
    port("pop_e", 1'b1, 4'h4, 64'h108, 16'h0014);
    check("pop_e_ready", {63'd0, bus.wb_ready}, 64'd0);
`ifdef WB_FWD_EN
    fwd_addr = 4'h2; #1;
    check("fwd_e_r2_hit",  {63'd0, fwd_hit}, 64'd1);
    check("fwd_e_r2_data", fwd_data, 64'hAB);
    fwd_addr = 4'h4; #1;
    check("fwd_e_r4_hit",  {63'd0, fwd_hit}, 64'd1);
    check("fwd_e_r4_data", fwd_data, 64'h108);
    fwd_addr = 4'hF; #1;
    check("fwd_e_rnone",   {63'd0, fwd_hit}, 64'd0);
`endif
    idle();
    port("pop_m", 1'b1, 4'h2, 64'hAB, 16'h0004);
    check("pop_m_ready", {63'd0, bus.wb_ready}, 64'd1);
`ifdef WB_FWD_EN
    fwd_addr = 4'h4; #1;
    check("fwd_m_r4_hit",  {63'd0, fwd_hit}, 64'd0);
    fwd_addr = 4'h2; #1;
    check("fwd_m_r2_data", fwd_data, 64'hAB);
    fwd_addr = 4'hF;
`endif
    idle();
    port("pop_done", 1'b0, 4'h0, 64'h0, 16'h0000);

    // popq %rsp: two writes to r4, valM last
    cyc(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h77);
    idle();
    port("poprsp_e", 1'b1, 4'h4, 64'h108, 16'h0010);
    idle();
    port("poprsp_m", 1'b1, 4'h4, 64'h77, 16'h0010);
    idle();
    port("poprsp_done", 1'b0, 4'h0, 64'h0, 16'h0000);

    // cmovXX cnd=0 then OPq rB=5 back-to-back
    cyc(1'b1, 4'h2, 4'hF, 4'h1, 1'b0, 64'hC0, 64'h0);
    cyc(1'b1, 4'h6, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0);
    port("cmov0", 1'b0, 4'h0, 64'h0, 16'h0000);
    check("cmov0_ready", {63'd0, bus.wb_ready}, 64'd1);
    idle();
    port("opq5", 1'b1, 4'h5, 64'h55, 16'h0020);
    idle();
    port("opq5_done", 1'b0, 4'h0, 64'h0, 16'h0000);

    // irmovq r6 then OPq r6 accepted during WR_E: set wins over clear
    cyc(1'b1, 4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0);
    cyc(1'b1, 4'h6, 4'hF, 4'h6, 1'b0, 64'h77, 64'h0);
    port("b2b_1", 1'b1, 4'h6, 64'h66, 16'h0040);
    check("b2b_ready", {63'd0, bus.wb_ready}, 64'd1);
    idle();
    port("b2b_2", 1'b1, 4'h6, 64'h77, 16'h0040);
    idle();
    port("b2b_done", 1'b0, 4'h0, 64'h0, 16'h0000);

    // mrmovq rA=9: M-only write
    cyc(1'b1, 4'h5, 4'h9, 4'hF, 1'b0, 64'h0, 64'h99);
    idle();
    port("mrm", 1'b1, 4'h9, 64'h99, 16'h0200);
    idle();

    // cmovXX cnd=1 rB=7
    cyc(1'b1, 4'h2, 4'hF, 4'h7, 1'b1, 64'h70, 64'h0);
    idle();
    port("cmov1", 1'b1, 4'h7, 64'h70, 16'h0080);
    idle();

    // Reset during WR_E of popq abandons both writes
    cyc(1'b1, 4'hB, 4'h2, 4'hF, 1'b0, 64'h108, 64'hAB);
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    port("mrst_e", 1'b1, 4'h4, 64'h108, 16'h0014);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    port("mrst_after", 1'b0, 4'h0, 64'h0, 16'h0000);
    check("mrst_waddr", {60'd0, rf_waddr}, 64'hF);
    check("mrst_ready", {63'd0, bus.wb_ready}, 64'd1);
    idle();
    check("mrst_nowm", {63'd0, rf_we}, 64'd0);

    // Undefined icode sets sticky bad_icode, no writes
    cyc(1'b1, 4'hC, 4'h1, 4'h2, 1'b0, 64'h5, 64'h6);
    idle();
    check("bad_flag", {63'd0, bad_icode}, 64'd1);
    port("bad", 1'b0, 4'h0, 64'h0, 16'h0000);

    // halt: sticky, blocks further accepts
    cyc(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    cyc(1'b1, 4'h3, 4'hF, 4'h3, 1'b0, 64'h33, 64'h0);
    check("halt_flag",  {63'd0, halted}, 64'd1);
    check("halt_ready", {63'd0, bus.wb_ready}, 64'd0);
    idle();
    port("halt_block", 1'b0, 4'h0, 64'h0, 16'h0000);
    check("halt_ready2", {63'd0, bus.wb_ready}, 64'd0);
    check("bad_sticky",  {63'd0, bad_icode}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
